// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and helpers used by the counter slice.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    // True when a nibble holds a legal decimal digit.
    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_count_src_if.sv
// Handshake/control bundle between the BCD count source and its consumer.
interface bcd_count_src_if #(
    parameter int unsigned NDIG = 2
);
    localparam int unsigned CW = 4 * NDIG;

    logic          en;
    logic          up_dn;
    logic          load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count;
    logic          out_valid;
    logic          out_ready;
    logic          wrap;
    logic          tc;
    logic          load_err;

    modport master (
        input  en, up_dn, load, load_val, out_ready,
        output count, out_valid, wrap, tc, load_err
    );

    modport slave (
        output en, up_dn, load, load_val, out_ready,
        input  count, out_valid, wrap, tc, load_err
    );

endinterface

// File: rtl/bcd_digit.sv
// One decimal digit register with load, increment and decrement (wrapping 9<->0).
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_d,
    input  logic             inc,
    input  logic             dec,
    output logic [BCD_W-1:0] q,
    output logic             at_max,
    output logic             at_min
);

    assign at_max = (q == BCD_MAX);
    assign at_min = (q == BCD_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_ZERO;
        end else if (ld) begin
            q <= ld_d;
        end else if (inc) begin
            q <= at_max ? BCD_ZERO : q + BCD_W'(1);
        end else if (dec) begin
            q <= at_min ? BCD_MAX : q - BCD_W'(1);
        end
    end

endmodule

// File: rtl/bcd_count_src.sv
// Multi-digit BCD up/down counter presented under a valid/ready handshake,
// with validated parallel load.
module bcd_count_src
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_count_src_if.master   bus
);

    localparam int unsigned CW = BCD_W * NDIG;

    logic [CW-1:0]   count;
    logic [NDIG-1:0] at_max;
    logic [NDIG-1:0] at_min;
    logic [NDIG-1:0] carry;
    logic [NDIG-1:0] borrow;
    logic [NDIG-1:0] digit_ok;
    logic            out_valid_q;
    logic            wrap_q;
    logic            load_err_q;
    logic            step;
    logic            load_ok;
    logic            all_max;
    logic            all_min;

    // A load always wins over a step, even when the transfer is accepted.
    assign step    = out_valid_q & bus.out_ready & bus.en & ~bus.load;
    assign load_ok = bus.load & (&digit_ok);
    assign all_max = &at_max;
    assign all_min = &at_min;

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        assign digit_ok[i] = is_bcd(bus.load_val[BCD_W*i +: BCD_W]);

        // Digit i moves only when every lower digit is at its rollover value.
        if (i == 0) begin : g_lsd
            assign carry[i]  = 1'b1;
            assign borrow[i] = 1'b1;
        end else begin : g_upper
            assign carry[i]  = &at_max[i-1:0];
            assign borrow[i] = &at_min[i-1:0];
        end

        bcd_digit u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .ld     (load_ok),
            .ld_d   (bus.load_val[BCD_W*i +: BCD_W]),
            .inc    (step & bus.up_dn & carry[i]),
            .dec    (step & ~bus.up_dn & borrow[i]),
            .q      (count[BCD_W*i +: BCD_W]),
            .at_max (at_max[i]),
            .at_min (at_min[i])
        );
    end

    // Valid comes up on the first edge out of reset, and stays up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b1;
            wrap_q      <= step & (bus.up_dn ? all_max : all_min);
            if (bus.load) begin
                load_err_q <= ~(&digit_ok);
            end
        end
    end

    assign bus.count     = count;
    assign bus.out_valid = out_valid_q;
    assign bus.wrap      = wrap_q;
    assign bus.load_err  = load_err_q;
    assign bus.tc        = bus.up_dn ? all_max : all_min;

endmodule

// File: tb/tb_bcd_count_src.sv
// Directed plus randomized check of bcd_count_src against an integer counter model.
module tb_bcd_count_src;

    localparam int unsigned NDIG = 2;
    localparam int unsigned CW   = 4 * NDIG;
    localparam int          MODV = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_count_src_if #(.NDIG(NDIG)) bus ();

    bcd_count_src #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer value modulo 10^NDIG.
    int mv     = 0;
    bit merr   = 1'b0;
    bit mvalid = 1'b0;
    bit mwrap  = 1'b0;

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < int'(NDIG); i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},     32'(bus.count),     32'(to_bcd(mv)));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mvalid));
        check({tag, ".wrap"},      32'(bus.wrap),      32'(mwrap));
        check({tag, ".load_err"},  32'(bus.load_err),  32'(merr));
        check({tag, ".tc"},        32'(bus.tc),
              32'(bus.up_dn ? (mv == MODV - 1) : (mv == 0)));
    endtask

    task automatic drive(input bit e, input bit r, input bit ud, input bit ld,
                         input logic [CW-1:0] lv);
        bus.en        = e;
        bus.out_ready = r;
        bus.up_dn     = ud;
        bus.load      = ld;
        bus.load_val  = lv;
    endtask

    // Advance the model from the inputs held across the edge, then clock.
    task automatic tick(input string tag);
        bit stp;
        bit ok;
        int val;
        int p;
        stp = mvalid && bus.out_ready && bus.en && !bus.load;
        if (bus.load) begin
            ok  = 1'b1;
            val = 0;
            p   = 1;
            for (int i = 0; i < int'(NDIG); i++) begin
                if (int'(bus.load_val[4*i +: 4]) > 9) ok = 1'b0;
                val = val + int'(bus.load_val[4*i +: 4]) * p;
                p   = p * 10;
            end
            if (ok) begin
                mv   = val;
                merr = 1'b0;
            end else begin
                merr = 1'b1;
            end
            mwrap = 1'b0;
        end else if (stp) begin
            if (bus.up_dn) begin
                mwrap = (mv == MODV - 1);
                mv    = (mv + 1) % MODV;
            end else begin
                mwrap = (mv == 0);
                mv    = (mv + MODV - 1) % MODV;
            end
        end else begin
            mwrap = 1'b0;
        end
        mvalid = 1'b1;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        #2;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;
        tick("release");

        // Mid-count asynchronous reset.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h37);
        tick("ld37");
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
        #2;
        rst_n  = 1'b0;
        mv     = 0;
        merr   = 1'b0;
        mvalid = 1'b0;
        mwrap  = 1'b0;
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick("rst_release");

        // Full up run including the 99 -> 00 wrap.
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 100; i++) tick("up_run");

        // Down across a tens boundary and through 00 -> 99.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
        tick("ld10");
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
        tick("dn09");
        tick("dn08");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        tick("ld00");
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
        tick("dn_wrap");
        tick("dn98");

        // Backpressure holds the count.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h42);
        tick("ld42");
        drive(1'b1, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) tick("stall");
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
        tick("resume");

        // Load validation and sticky error.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h57);
        tick("ld57");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
        tick("ld5A_bad");
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        tick("err_sticky");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h12);
        tick("ld12");

        // Load beats a same-cycle accepted step.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h19);
        tick("ld19");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h63);
        tick("ld_vs_step");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
        tick("ld99");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
        tick("ld_at_tc_nowrap");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hF0);
        tick("bad_ld_nostep");

        // Randomized traffic, including up_dn flips and occasional bad loads.
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                  CW'($urandom));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
